// File: rtl/mskaes_serial_fsm_if.sv
// Control bundle between the masked serial AES controller and its surroundings.
// Handshake rules: the input side uses valid_in/in_ready. valid_in stays asserted
// until a run has been accepted, and in_ready is registered so it never follows
// a same-cycle input. The output side uses cipher_valid/out_ready. cipher_valid stays
// asserted until a cycle in which out_ready is high, and the result is fetched in
// that cycle. rnd_valid qualifies the fresh mask randomness for the current cycle.
interface mskaes_serial_fsm_if;
  logic       valid_in;
  logic       in_ready;
  logic       out_ready;
  logic       cipher_valid;
  logic       busy;
  logic       abort;
  logic       rnd_valid;
  logic       pre_need_rnd;
  logic       pipe_en;
  logic       global_init;
  logic       state_enable;
  logic       state_init;
  logic       state_en_MC;
  logic       state_en_loop;
  logic       KH_init;
  logic       KH_enable;
  logic       KH_loop;
  logic       KH_add_from_sb;
  logic       rcon_rst;
  logic       rcon_update;
  logic       sbox_valid_in;
  logic       feed_sb_key;
  logic       enable_key_add;
  logic [3:0] round_idx;

  // Controller side
  modport master (
    input  valid_in, out_ready, abort, rnd_valid,
    output in_ready, cipher_valid, busy, pre_need_rnd, pipe_en,
           global_init, state_enable, state_init, state_en_MC, state_en_loop,
           KH_init, KH_enable, KH_loop, KH_add_from_sb,
           rcon_rst, rcon_update, sbox_valid_in, feed_sb_key, enable_key_add,
           round_idx
  );

  // Environment / datapath side
  modport slave (
    output valid_in, out_ready, abort, rnd_valid,
    input  in_ready, cipher_valid, busy, pre_need_rnd, pipe_en,
           global_init, state_enable, state_init, state_en_MC, state_en_loop,
           KH_init, KH_enable, KH_loop, KH_add_from_sb,
           rcon_rst, rcon_update, sbox_valid_in, feed_sb_key, enable_key_add,
           round_idx
  );
endinterface

// File: rtl/mskaes_serial_fsm.sv
// Control FSM for the masked, column-serial AES datapath. Each round streams
// the state through the Sbox (SERIAL_LAT cycles) and waits for the pipeline to
// drain (SBOX_LAT cycles). The key schedule runs in the same window. The whole
// core freezes while fresh randomness is missing, and an abort returns it to idle.
module mskaes_serial_fsm #(
  parameter int SERIAL_LAT = 4,
  parameter int SBOX_LAT   = 6,
  parameter int NR         = 10
) (
  input  logic                clk,
  input  logic                rst,
  mskaes_serial_fsm_if.master bus,
  output logic [2:0]          dbg_state
);

  localparam int RL = SBOX_LAT + SERIAL_LAT;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FIRST_SB_K = 3'd1,
    S_ROUND      = 3'd2,
    S_LAST_ROUND = 3'd3,
    S_AK_FINAL   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] round_q, round_d;
  logic       in_ready_q, in_ready_d;
  logic       cv_q, cv_set;

  logic start, flush_ok;
  logic aksb, kexp_first, kexp, last_cyc, ak_last;

  logic pipe_en, pre_need_rnd;
  logic global_init, state_enable, state_init, state_en_MC, state_en_loop;
  logic kh_init, kh_enable, kh_loop, kh_add_from_sb;
  logic rcon_rst, rcon_update, sbox_valid_in, feed_sb_key, enable_key_add;

  // The datapath may be overwritten only when no result is waiting to be fetched
  // or when the result is being fetched in this cycle.
  assign flush_ok = ~cv_q | bus.out_ready;
  assign start    = bus.valid_in & flush_ok;

  // Position inside a round. The key expansion window starts when the first Sbox output is ready.
  assign aksb       = cnt_q < 5'(SERIAL_LAT);
  assign kexp_first = cnt_q == 5'(SBOX_LAT - 1);
  assign kexp       = (cnt_q >= 5'(SBOX_LAT - 1)) && (cnt_q < 5'(SBOX_LAT - 1 + SERIAL_LAT));
  assign last_cyc   = cnt_q == 5'(RL - 1);
  assign ak_last    = cnt_q == 5'(SERIAL_LAT - 1);

  // Next-state, counters and per-cycle datapath strobes
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    round_d        = round_q;
    cv_set         = 1'b0;
    pipe_en        = 1'b1;
    pre_need_rnd   = 1'b0;
    global_init    = 1'b0;
    state_enable   = 1'b0;
    state_init     = 1'b0;
    state_en_MC    = 1'b0;
    state_en_loop  = 1'b0;
    kh_init        = 1'b0;
    kh_enable      = 1'b0;
    kh_loop        = 1'b0;
    kh_add_from_sb = 1'b0;
    rcon_rst       = 1'b0;
    rcon_update    = 1'b0;
    sbox_valid_in  = 1'b0;
    feed_sb_key    = 1'b0;
    enable_key_add = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE) begin
        pre_need_rnd = start;
        // Load or flush the holders whenever the output side is not blocked
        if (flush_ok) begin
          global_init  = 1'b1;
          state_init   = 1'b1;
          kh_init      = 1'b1;
          state_enable = 1'b1;
          kh_enable    = 1'b1;
        end
        if (start && bus.rnd_valid) begin
          rcon_rst = 1'b1;
          cnt_d    = '0;
          round_d  = '0;
          state_d  = S_FIRST_SB_K;
        end
      end else begin
        pre_need_rnd = 1'b1;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (!bus.rnd_valid) begin
          pipe_en = 1'b0;
        end else begin
          unique case (state_q)
            S_FIRST_SB_K: begin
              sbox_valid_in = 1'b1;
              feed_sb_key   = 1'b1;
              cnt_d         = '0;
              state_d       = S_ROUND;
            end
            S_ROUND, S_LAST_ROUND: begin
              enable_key_add = aksb;
              state_en_loop  = aksb;
              kh_loop        = aksb;
              kh_add_from_sb = kexp_first & ~aksb;
              kh_enable      = aksb | kexp;
              state_enable   = ~kexp_first;
              state_en_MC    = (state_q == S_ROUND);
              sbox_valid_in  = aksb | (last_cyc & (state_q == S_ROUND));
              if (last_cyc) begin
                round_d = round_q + 4'd1;
                cnt_d   = '0;
                if (state_q == S_ROUND) begin
                  feed_sb_key = 1'b1;
                  rcon_update = 1'b1;
                  state_d     = (round_q == 4'(NR - 2)) ? S_LAST_ROUND : S_ROUND;
                end else begin
                  state_d = S_AK_FINAL;
                end
              end else begin
                cnt_d = cnt_q + 5'd1;
              end
            end
            S_AK_FINAL: begin
              enable_key_add = 1'b1;
              state_en_loop  = 1'b1;
              kh_loop        = 1'b1;
              state_enable   = 1'b1;
              kh_enable      = 1'b1;
              if (ak_last) begin
                cv_set  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
              end else begin
                cnt_d = cnt_q + 5'd1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  // in_ready is re-armed in idle only, one cycle after the output side frees up
  always_comb begin
    in_ready_d = 1'b0;
    if (state_q == S_IDLE) in_ready_d = in_ready_q ? ~bus.valid_in : flush_ok;
  end

  // State, counters and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      round_q    <= '0;
      in_ready_q <= 1'b1;
      cv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      round_q    <= round_d;
      in_ready_q <= in_ready_d;
      if (cv_q && bus.out_ready) cv_q <= 1'b0;
      else if (cv_set)           cv_q <= 1'b1;
    end
  end

  // The key expansion window has to close inside one round, and the parameters must be legal
  param_check_a: assert property (@(posedge clk) disable iff (rst)
    (SBOX_LAT - 1 + SERIAL_LAT <= RL) && (SERIAL_LAT >= 1) && (SERIAL_LAT <= 8) &&
    (SBOX_LAT >= 2) && (SBOX_LAT <= 8) && (NR >= 2) && (NR <= 15));

  assign bus.in_ready       = in_ready_q;
  assign bus.cipher_valid   = cv_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.pre_need_rnd   = pre_need_rnd;
  assign bus.pipe_en        = pipe_en;
  assign bus.global_init    = global_init;
  assign bus.state_enable   = state_enable;
  assign bus.state_init     = state_init;
  assign bus.state_en_MC    = state_en_MC;
  assign bus.state_en_loop  = state_en_loop;
  assign bus.KH_init        = kh_init;
  assign bus.KH_enable      = kh_enable;
  assign bus.KH_loop        = kh_loop;
  assign bus.KH_add_from_sb = kh_add_from_sb;
  assign bus.rcon_rst       = rcon_rst;
  assign bus.rcon_update    = rcon_update;
  assign bus.sbox_valid_in  = sbox_valid_in;
  assign bus.feed_sb_key    = feed_sb_key;
  assign bus.enable_key_add = enable_key_add;
  assign bus.round_idx      = round_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_mskaes_serial_fsm.sv
// Directed bench for the masked serial AES controller: default core plus an
// AES-256-style instance (NR=14, SBOX_LAT=4, SERIAL_LAT=4).
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// Cycle 0 of each scenario is the cycle in which start is presented.
module tb_mskaes_serial_fsm;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_a, dbg_b;
  int         checks;
  int         failures;
  logic [19:0] nom_trace [0:127];

  mskaes_serial_fsm_if ifa ();
  mskaes_serial_fsm_if ifb ();

  mskaes_serial_fsm dut_a (.clk(clk), .rst(rst), .bus(ifa), .dbg_state(dbg_a));
  mskaes_serial_fsm #(.SERIAL_LAT(4), .SBOX_LAT(4), .NR(14)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .dbg_state(dbg_b)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] strobes_a();
    return {ifa.global_init, ifa.state_enable, ifa.state_init, ifa.state_en_MC,
            ifa.state_en_loop, ifa.KH_init, ifa.KH_enable, ifa.KH_loop, ifa.KH_add_from_sb,
            ifa.rcon_rst, ifa.rcon_update, ifa.sbox_valid_in, ifa.feed_sb_key, ifa.enable_key_add};
  endfunction

  function automatic logic [19:0] trace_a();
    return {strobes_a(), ifa.round_idx, ifa.busy, ifa.pipe_en};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.valid_in = 1'b0; ifa.out_ready = 1'b1; ifa.rnd_valid = 1'b1; ifa.abort = 1'b0;
    ifb.valid_in = 1'b0; ifb.out_ready = 1'b1; ifb.rnd_valid = 1'b1; ifb.abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.valid_in = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ifa.in_ready); end
    checks++; if (ifa.cipher_valid !== 1'b0) begin failures++; $display("FAIL reset_cipher_valid got=%b exp=0", ifa.cipher_valid); end
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifa.busy); end
    checks++; if (ifa.pipe_en !== 1'b1) begin failures++; $display("FAIL reset_pipe_en got=%b exp=1", ifa.pipe_en); end
    checks++; if (strobes_a() !== 14'd0) begin failures++; $display("FAIL reset_strobes got=%h exp=0", strobes_a()); end
    checks++; if (ifa.pre_need_rnd !== 1'b0) begin failures++; $display("FAIL reset_pre_need_rnd got=%b exp=0", ifa.pre_need_rnd); end
    checks++; if (ifa.round_idx !== 4'd0 || dbg_a !== 3'd0) begin failures++; $display("FAIL reset_round_state got=%0d/%0d exp=0/0", ifa.round_idx, dbg_a); end
    ifa.valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int first_cv = -1;
    int kh_cnt = 0;
    int rc_cnt = 0;
    int ir_bad = 0;
    logic ir107 = 1'b0, busy107 = 1'b0, cv107 = 1'b1;
    do_reset();
    for (int c = 0; c <= 110; c++) begin
      @(negedge clk);
      if (c == 0) ifa.valid_in = 1'b1;
      #1;
      nom_trace[c] = trace_a();
      if (ifa.cipher_valid && first_cv < 0) first_cv = c;
      if (c <= 105) begin kh_cnt += int'(ifa.KH_add_from_sb); rc_cnt += int'(ifa.rcon_update); end
      if (c >= 1 && c <= 106 && ifa.in_ready) ir_bad++;
      if (c == 107) begin ir107 = ifa.in_ready; busy107 = ifa.busy; cv107 = ifa.cipher_valid; end
      if (c == 0) begin
        checks++; if (ifa.global_init !== 1'b1 || ifa.busy !== 1'b0) begin failures++; $display("FAIL nom_start_c0 got=%b%b exp=10", ifa.global_init, ifa.busy); end
      end
      if (c == 1) begin
        checks++; if ({ifa.sbox_valid_in, ifa.feed_sb_key, ifa.round_idx} !== 6'b110000) begin failures++; $display("FAIL nom_first_sb_k got=%b exp=110000", {ifa.sbox_valid_in, ifa.feed_sb_key, ifa.round_idx}); end
      end
      if (c == 7) begin
        checks++; if (ifa.KH_add_from_sb !== 1'b1 || ifa.state_enable !== 1'b0) begin failures++; $display("FAIL nom_kexp_first got=%b%b exp=10", ifa.KH_add_from_sb, ifa.state_enable); end
      end
      if (c == 85) begin
        checks++; if (ifa.state_en_MC !== 1'b1 || ifa.round_idx !== 4'd8) begin failures++; $display("FAIL nom_round8 got=%b/%0d exp=1/8", ifa.state_en_MC, ifa.round_idx); end
      end
      if (c == 95) begin
        checks++; if (ifa.state_en_MC !== 1'b0 || ifa.round_idx !== 4'd9) begin failures++; $display("FAIL nom_last_round got=%b/%0d exp=0/9", ifa.state_en_MC, ifa.round_idx); end
      end
      if (c == 103) begin
        checks++; if (ifa.enable_key_add !== 1'b1 || ifa.round_idx !== 4'd10 || ifa.sbox_valid_in !== 1'b0) begin failures++; $display("FAIL nom_ak_final got=%b/%0d/%b exp=1/10/0", ifa.enable_key_add, ifa.round_idx, ifa.sbox_valid_in); end
      end
    end
    checks++; if (first_cv != 106) begin failures++; $display("FAIL nom_latency got=%0d exp=106", first_cv); end
    checks++; if (kh_cnt != 10) begin failures++; $display("FAIL nom_kh_add_count got=%0d exp=10", kh_cnt); end
    checks++; if (rc_cnt != 9) begin failures++; $display("FAIL nom_rcon_count got=%0d exp=9", rc_cnt); end
    checks++; if (ir_bad != 0) begin failures++; $display("FAIL nom_in_ready_low got=%0d exp=0", ir_bad); end
    checks++; if ({ir107, busy107, cv107} !== 3'b110) begin failures++; $display("FAIL nom_back_to_back got=%b exp=110", {ir107, busy107, cv107}); end
    ifa.valid_in = 1'b0;
  endtask

  task automatic test_nr14();
    int first_cv = -1;
    int rc_cnt = 0;
    int mc_last = 0;
    int mc_mid = 0;
    logic [3:0] ridx106 = 4'd0;
    do_reset();
    for (int c = 0; c <= 120; c++) begin
      @(negedge clk);
      if (c == 0) ifb.valid_in = 1'b1;
      if (c == 1) ifb.valid_in = 1'b0;
      #1;
      if (ifb.cipher_valid && first_cv < 0) first_cv = c;
      if (c < 118) rc_cnt += int'(ifb.rcon_update);
      if (c >= 106 && c <= 113) mc_last += int'(ifb.state_en_MC);
      if (c >= 2 && c <= 105) mc_mid += int'(ifb.state_en_MC);
      if (c == 106) ridx106 = ifb.round_idx;
    end
    checks++; if (first_cv != 118) begin failures++; $display("FAIL nr14_latency got=%0d exp=118", first_cv); end
    checks++; if (rc_cnt != 13) begin failures++; $display("FAIL nr14_rcon_count got=%0d exp=13", rc_cnt); end
    checks++; if (mc_last != 0) begin failures++; $display("FAIL nr14_mc_final got=%0d exp=0", mc_last); end
    checks++; if (mc_mid != 104) begin failures++; $display("FAIL nr14_mc_rounds got=%0d exp=104", mc_mid); end
    checks++; if (ridx106 !== 4'd13) begin failures++; $display("FAIL nr14_last_idx got=%0d exp=13", ridx106); end
  endtask

  task automatic test_stall();
    int first_cv = -1;
    int pe_low = 0;
    int stall_bad = 0;
    int trace_bad = 0;
    int first_bad = -1;
    logic [19:0] t;
    do_reset();
    for (int c = 0; c <= 112; c++) begin
      @(negedge clk);
      ifa.valid_in  = (c == 0);
      ifa.rnd_valid = !(c >= 40 && c <= 44);
      #1;
      t = trace_a();
      if (ifa.cipher_valid && first_cv < 0) first_cv = c;
      if (!ifa.pipe_en) pe_low++;
      if (c >= 40 && c <= 44) begin
        if (ifa.pipe_en !== 1'b0 || strobes_a() !== 14'd0 || ifa.pre_need_rnd !== 1'b1 || ifa.busy !== 1'b1) stall_bad++;
      end else if (c <= 110) begin
        if (t !== ((c < 40) ? nom_trace[c] : nom_trace[c - 5])) begin
          trace_bad++;
          if (first_bad < 0) first_bad = c;
        end
      end
    end
    ifa.rnd_valid = 1'b1;
    checks++; if (pe_low != 5) begin failures++; $display("FAIL stall_pipe_en_low got=%0d exp=5", pe_low); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_frozen got=%0d exp=0", stall_bad); end
    checks++; if (first_cv != 111) begin failures++; $display("FAIL stall_latency got=%0d exp=111", first_cv); end
    checks++; if (trace_bad != 0) begin failures++; $display("FAIL stall_shifted_trace got=%0d bad cycles (first %0d) exp=0", trace_bad, first_bad); end
  endtask

  task automatic test_abort();
    int first_cv = -1;
    logic [13:0] s50 = '1;
    logic b51 = 1'b1, b52 = 1'b0;
    do_reset();
    for (int c = 0; c <= 160; c++) begin
      @(negedge clk);
      if (c == 0) ifa.valid_in = 1'b1;
      ifa.abort = (c == 50);
      #1;
      if (ifa.cipher_valid && first_cv < 0) first_cv = c;
      if (c == 50) s50 = strobes_a();
      if (c == 51) b51 = ifa.busy;
      if (c == 52) b52 = ifa.busy;
    end
    ifa.valid_in = 1'b0;
    checks++; if (s50 !== 14'd0) begin failures++; $display("FAIL abort_strobes got=%h exp=0", s50); end
    checks++; if (b51 !== 1'b0) begin failures++; $display("FAIL abort_busy_c51 got=%b exp=0", b51); end
    checks++; if (b52 !== 1'b1) begin failures++; $display("FAIL abort_restart_c52 got=%b exp=1", b52); end
    checks++; if (first_cv != 157) begin failures++; $display("FAIL abort_next_latency got=%0d exp=157", first_cv); end
  endtask

  task automatic test_back_to_back();
    int first_cv = -1;
    int second_cv = -1;
    int hold_bad = 0;
    logic [3:0] at120 = '0;
    logic [2:0] at121 = '0;
    do_reset();
    for (int c = 0; c <= 230; c++) begin
      @(negedge clk);
      if (c == 0) ifa.valid_in = 1'b1;
      ifa.out_ready = (c == 0) || (c >= 120);
      #1;
      if (ifa.cipher_valid && first_cv < 0) first_cv = c;
      if (ifa.cipher_valid && c > 121 && second_cv < 0) second_cv = c;
      if (c >= 106 && c <= 119) begin
        if (ifa.cipher_valid !== 1'b1 || ifa.busy !== 1'b0 || ifa.global_init !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.pre_need_rnd !== 1'b0) hold_bad++;
      end
      if (c == 120) at120 = {ifa.global_init, ifa.in_ready, ifa.busy, ifa.cipher_valid};
      if (c == 121) at121 = {ifa.in_ready, ifa.busy, ifa.cipher_valid};
    end
    ifa.valid_in = 1'b0;
    ifa.out_ready = 1'b1;
    checks++; if (first_cv != 106) begin failures++; $display("FAIL bp_first_latency got=%0d exp=106", first_cv); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_bad); end
    checks++; if (at120 !== 4'b1001) begin failures++; $display("FAIL bp_fetch_start_c120 got=%b exp=1001", at120); end
    checks++; if (at121 !== 3'b110) begin failures++; $display("FAIL bp_c121 got=%b exp=110", at121); end
    checks++; if (second_cv != 226) begin failures++; $display("FAIL bp_second_latency got=%0d exp=226", second_cv); end
  endtask

  task automatic test_async_reset();
    logic pre_ir = 1'b1, pre_busy = 1'b0;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 0) ifa.valid_in = 1'b1;
      #1;
      if (c == 30) begin pre_ir = ifa.in_ready; pre_busy = ifa.busy; end
    end
    checks++; if ({pre_ir, pre_busy} !== 2'b01) begin failures++; $display("FAIL arst_pre got=%b exp=01", {pre_ir, pre_busy}); end
    rst = 1'b1;
    #1;
    checks++; if ({ifa.in_ready, ifa.busy, ifa.cipher_valid} !== 3'b100) begin failures++; $display("FAIL arst_outputs got=%b exp=100", {ifa.in_ready, ifa.busy, ifa.cipher_valid}); end
    checks++; if (dbg_a !== 3'd0 || ifa.round_idx !== 4'd0) begin failures++; $display("FAIL arst_state got=%0d/%0d exp=0/0", dbg_a, ifa.round_idx); end
    ifa.valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scenario sequence and summary
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ifa.valid_in = 1'b0; ifa.out_ready = 1'b1; ifa.rnd_valid = 1'b1; ifa.abort = 1'b0;
    ifb.valid_in = 1'b0; ifb.out_ready = 1'b1; ifb.rnd_valid = 1'b1; ifb.abort = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_nominal();
    test_nr14();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mskaes_serial_fsm.md
Name: mskaes_serial_fsm

Overview:
- Parametrised control FSM for the masked, column-serial AES datapath.
- Sequences the state holder, key holder, RCON holder, Sbox feed and key addition across rounds.
- Generalises the fixed 32-bit/AES-128 controller with the following:
  - round count and Sbox/serialisation latencies set as parameters;
  - randomness-starvation stall (whole core freezes while rnd_valid is low);
  - synchronous abort.
- Sits between the SVRS input/output interfaces and the datapath top.

Parameters:
- SERIAL_LAT, 4, cycles to stream one state through the Sbox (state bits / datapath width); legal 1..8.
- SBOX_LAT, 6, Sbox pipeline latency in cycles; legal 2..8.
- NR, 10, total AES rounds (10/12/14); legal 2..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- valid_in  in  1  input data valid; sticky until in_ready handshake.
- in_ready  out  1  registered input ready.
- out_ready  in  1  downstream ready.
- cipher_valid  out  1  registered output valid; sticky until fetched.
- busy  out  1  state != IDLE.
- abort  in  1  synchronous abort request.
- rnd_valid  in  1  randomness available for current cycle.
- pre_need_rnd  out  1  core requests randomness.
- pipe_en  out  1  global clock-enable for Sbox pipeline and holders; 0 during stall.
- global_init, state_enable, state_init, state_en_MC, state_en_loop  out  1 each  state-holder control.
- KH_init, KH_enable, KH_loop, KH_add_from_sb  out  1 each  key-holder control.
- rcon_rst, rcon_update  out  1 each  RCON control.
- sbox_valid_in, feed_sb_key, enable_key_add  out  1 each  Sbox/AK control.
- round_idx  out  4  current round number (0 during first Sbox-key cycle).

Behaviour:
- Reset (async):
  - FSM state = IDLE.
  - in_ready = 1; cipher_valid = 0; counters = 0.
  - All combinational strobes = 0, except pipe_en = 1.
- Definitions:
  - cnt = intra-round counter.
  - RL = SBOX_LAT + SERIAL_LAT.
  - AKSB = cnt < SERIAL_LAT.
  - KEXP_FIRST = cnt == SBOX_LAT-1 (also key_from_sbox).
  - KEXP = SBOX_LAT-1 <= cnt < SBOX_LAT-1+SERIAL_LAT.
  - last_cyc = cnt == RL-1.
- start = valid_in & (~cipher_valid | out_ready).
- States:
  - IDLE:
    - On start: global_init = state_init = KH_init = state_enable = KH_enable = 1; rcon_rst = 1; counters cleared; -> FIRST_SB_K.
    - Else, if (~cipher_valid | out_ready): same init/enable strobes (core flush), no transition.
  - FIRST_SB_K (1 cycle): sbox_valid_in = feed_sb_key = 1; cnt cleared; -> ROUND.
  - ROUND, strobes:
    - sbox_valid_in when AKSB | last_cyc.
    - enable_key_add and state_en_loop and KH_loop when AKSB.
    - KH_add_from_sb when KEXP_FIRST & ~AKSB.
    - KH_enable when AKSB | KEXP.
    - state_enable when ~key_from_sbox.
    - state_en_MC = 1.
    - feed_sb_key at last_cyc.
  - ROUND, transition at last_cyc: round_idx++, rcon_update = 1, cnt cleared; -> LAST_ROUND if round_idx == NR-2, else stay in ROUND.
  - LAST_ROUND:
    - Same strobes as ROUND, except: no state_en_MC; no sbox_valid_in and no feed_sb_key at last_cyc.
    - At last_cyc: round_idx++, cnt cleared; -> AK_FINAL.
  - AK_FINAL:
    - enable_key_add = state_en_loop = KH_loop = state_enable = KH_enable = 1.
    - At cnt == SERIAL_LAT-1: set cipher_valid; -> IDLE.
- Stall:
  - Applies in any non-IDLE state with rnd_valid = 0.
  - pipe_en = 0; all strobes forced 0; state, cnt, round_idx hold.
  - pre_need_rnd stays 1.
  - Resumes exactly where it froze.
  - IDLE start also requires rnd_valid; without it, the start is deferred.
- pre_need_rnd = 1 except in IDLE with no start.
- in_ready (registered), next value:
  - in IDLE: if in_ready then ~valid_in, else (~cipher_valid | out_ready);
  - in all other states: 0.
- cipher_valid: cleared when cipher_valid & out_ready (priority over set); set at end of AK_FINAL.
- Abort:
  - In any non-IDLE state, abort forces -> IDLE next cycle.
  - All strobes 0 in that cycle; cipher_valid not set.
  - Takes priority over stall and transitions.
  - Ignored in IDLE.
- Latency: cipher_valid rises 2 + NR·RL + SERIAL_LAT cycles after the start cycle, plus the number of stall cycles.
- Assertion: SBOX_LAT-1+SERIAL_LAT <= RL, i.e. the key expansion window fits inside one round.

Test Plan:
- Defaults, valid_in = 1 held, out_ready = 1, rnd_valid = 1 -> global_init at cycle 0; cipher_valid high at cycle 106; in_ready pulses per rule; KH_add_from_sb exactly 10 pulses.
- NR = 14, SBOX_LAT = 4, SERIAL_LAT = 4 -> cipher_valid at cycle 2+112+4 = 118; rcon_update 13 pulses; state_en_MC 0 throughout the final round.
- Defaults, rnd_valid low for 5 cycles starting at cycle 40 -> pipe_en = 0 and all strobes 0 for exactly those 5 cycles; cipher_valid at cycle 111; strobe trace otherwise identical, shifted by 5.
- abort at cycle 50 -> busy = 0 at cycle 51; cipher_valid never set; next start produces the normal 106-cycle run.
- out_ready = 0 after first result, valid_in = 1 continuously -> second run does not start until out_ready rises; start occurs in the same cycle the fetch completes; in_ready never combinationally follows out_ready.
- rst asserted asynchronously mid-ROUND -> outputs reach reset values immediately without a clock edge: in_ready = 1, busy = 0, cipher_valid = 0.
